keypad_scanner: RTL

//  Scans a 4x4 active-low matrix keypad, debounces it and presents a 5-bit key code.

---
 rtl/keypad_scanner_pkg.sv | 32 +++
 rtl/key_debounce.sv | 56 +++++
 rtl/keypad_scanner.sv | 115 +++++++++++
 3 files changed

// File: rtl/keypad_scanner_pkg.sv
// Key codes shared with the downstream calculator FSM, plus counter width helper.
// KEY_0..KEY_9 are contiguous so consumers can range-compare digits.
package keypad_scanner_pkg;

    localparam logic [4:0] KEY_0    = 5'd0;
    localparam logic [4:0] KEY_1    = 5'd1;
    localparam logic [4:0] KEY_2    = 5'd2;
    localparam logic [4:0] KEY_3    = 5'd3;
    localparam logic [4:0] KEY_4    = 5'd4;
    localparam logic [4:0] KEY_5    = 5'd5;
    localparam logic [4:0] KEY_6    = 5'd6;
    localparam logic [4:0] KEY_7    = 5'd7;
    localparam logic [4:0] KEY_8    = 5'd8;
    localparam logic [4:0] KEY_9    = 5'd9;
    localparam logic [4:0] KEY_A    = 5'd10;
    localparam logic [4:0] KEY_B    = 5'd11;
    localparam logic [4:0] KEY_C    = 5'd12;
    localparam logic [4:0] KEY_D    = 5'd13;
    localparam logic [4:0] KEY_E    = 5'd14;
    localparam logic [4:0] KEY_F    = 5'd15;
    localparam logic [4:0] KEY_NONE = 5'd16;

    // Bits needed to hold 0..value-1, never less than one.
    function automatic int clog2b(input int value);
        int w;
        w = 1;
        while ((1 << w) < value)
            w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: accepts a per-frame key code once it repeats DEBOUNCE frames in a row.
// Latency: key updates on the frame_done edge of the DEBOUNCE-th identical frame.
// Backpressure: none; frame_done is a free-running pulse and is never stalled.
module key_debounce
    import keypad_scanner_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] frame_code,
    input  logic       frame_done,
    output logic [4:0] key,
    output logic       key_strobe
);

    localparam int             CW      = clog2b(DEBOUNCE + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE);

    logic [4:0]    cand;
    logic [4:0]    cand_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          take;

    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (frame_done) begin
            if (frame_code == cand) begin
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            end else begin
                cand_nxt = frame_code;
                cnt_nxt  = CW'(1);
            end
        end
        // Judged on the updated count so DEBOUNCE==1 follows every frame directly.
        take = frame_done && (cnt_nxt == CNT_MAX) && (cand_nxt != key);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cand       <= KEY_NONE;
            cnt        <= '0;
            key        <= KEY_NONE;
            key_strobe <= 1'b0;
        end else begin
            cand       <= cand_nxt;
            cnt        <= cnt_nxt;
            key_strobe <= take && (cand_nxt != KEY_NONE);
            if (take)
                key <= cand_nxt;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x4 active-low keypad one column per SCAN_DIV cycles, rejects ghosts, debounces.
// Latency: key changes DEBOUNCE frames (4*SCAN_DIV cycles each) after a steady press or release.
// Backpressure: none; the downstream FSM samples key/key_strobe whenever it likes.
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [4:0] key,
    output logic       key_strobe
);

    localparam int            TW        = clog2b(SCAN_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    logic [TW-1:0] tick;
    logic [1:0]    col_idx;
    logic [11:0]   acc;        // pressed flags of columns 0..2, bit c*4+r
    logic [15:0]   pressed;
    logic          tick_end;
    logic          frame_done;
    logic [4:0]    frame_code;
    logic [4:0]    hits;
    logic [1:0]    hit_r;
    logic [1:0]    hit_c;

    function automatic logic [4:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0:    key_map = KEY_1;
            4'h1:    key_map = KEY_2;
            4'h2:    key_map = KEY_3;
            4'h3:    key_map = KEY_A;
            4'h4:    key_map = KEY_4;
            4'h5:    key_map = KEY_5;
            4'h6:    key_map = KEY_6;
            4'h7:    key_map = KEY_B;
            4'h8:    key_map = KEY_7;
            4'h9:    key_map = KEY_8;
            4'hA:    key_map = KEY_9;
            4'hB:    key_map = KEY_C;
            4'hC:    key_map = KEY_E;
            4'hD:    key_map = KEY_0;
            4'hE:    key_map = KEY_F;
            default: key_map = KEY_D;
        endcase
    endfunction

    assign tick_end   = (tick == TICK_LAST);
    assign frame_done = tick_end && (col_idx == 2'd3);
    assign col        = ~(4'b0001 << col_idx);

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_s1  <= 4'hF;
            row_s2  <= 4'hF;
            tick    <= '0;
            col_idx <= '0;
            acc     <= '0;
        end else begin
            row_s1 <= row;
            row_s2 <= row_s1;
            if (tick_end) begin
                tick    <= '0;
                col_idx <= col_idx + 2'd1;
                // Column 3 is consumed live at frame end and never stored.
                case (col_idx)
                    2'd0:    acc[3:0]  <= ~row_s2;
                    2'd1:    acc[7:4]  <= ~row_s2;
                    2'd2:    acc[11:8] <= ~row_s2;
                    default: acc       <= acc;
                endcase
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

    assign pressed = {~row_s2, acc};

    always_comb begin
        hits  = '0;
        hit_r = '0;
        hit_c = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4 + r]) begin
                    hits  = hits + 5'd1;
                    hit_r = 2'(r);
                    hit_c = 2'(c);
                end
            end
        end
        // Anything but a single intersection is idle or a ghost pattern.
        frame_code = (hits == 5'd1) ? key_map(hit_r, hit_c) : KEY_NONE;
    end

    key_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_code (frame_code),
        .frame_done (frame_done),
        .key        (key),
        .key_strobe (key_strobe)
    );

endmodule
